dff_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares one WIDTH-bit register (bank of sync-reset D flip-flops)

---
 rtl/dff_write_arbiter_pkg.sv | 54 +++++
 rtl/dff_write_arbiter_bank.sv | 43 ++++
 rtl/dff_write_arbiter.sv | 122 ++++++++++++
 tb/tb_dff_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// Package: dff_arb_pkg
// Purpose: shared types and helpers for the round-robin write arbiter that
//          owns the shared register.
//          - arb_state_t : arbiter FSM states (free arbitration vs. locked owner)
//          - rr_pick     : round-robin search for the first active request
//          - onehot      : index to one-hot grant vector
// Helpers work on fixed maximum widths so callers with any NREQ up to
// MAX_NREQ can share them; callers zero-extend requests and truncate results.
// ----------------------------------------------------------------------------
package dff_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_NREQ = 32;
    localparam int MAX_IDW  = 5;

    typedef struct packed {
        logic                found;
        logic [MAX_IDW-1:0]  idx;
    } rr_pick_t;

    // Scan ptr, ptr+1, ... wrapping at n. ptr is always below n, so a single
    // conditional subtract replaces the modulo.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                         input logic [MAX_IDW-1:0]  ptr,
                                         input int                  n);
        rr_pick_t r;
        int       cand;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < n) begin
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (!r.found && req[cand]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_IDW'(cand);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDW-1:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/dff_write_arbiter_bank.sv
// ----------------------------------------------------------------------------
// Module: dff_bank
// Purpose: WIDTH-bit register of D flip-flops with load enable and a
//          synchronous active-low reset to RST_VAL.
// Ports:
//   clk  in   clock, updates on posedge
//   rst  in   synchronous reset, active-low
//   en   in   load d into the register this edge
//   d    in   WIDTH-bit next value
//   q    out  WIDTH-bit register contents
// ----------------------------------------------------------------------------
module dff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// ----------------------------------------------------------------------------
// Module: dff_write_arbiter
// Purpose: round-robin arbiter sharing one WIDTH-bit register between NREQ
//          requesters. At most one write per cycle; the winner may lock the
//          register for back-to-back writes. All outputs are registered.
// Ports:
//   clk      in   clock, posedge
//   rst      in   synchronous reset, active-low
//   req      in   [NREQ]        per-requester write request, held until granted
//   lock     in   [NREQ]        per-requester lock hint, sampled with req
//   wdata    in   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   gnt      out  [NREQ]        one-hot grant, high one cycle per accepted write
//   gnt_vld  out  OR of gnt
//   gnt_id   out  [IDW]         index of the last granted requester
//   locked   out  1 while the register is locked to an owner
//   q        out  [WIDTH]       shared register contents
// NREQ must not exceed dff_arb_pkg::MAX_NREQ.
// ----------------------------------------------------------------------------
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  gnt_vld,
    output logic [IDW-1:0]        gnt_id,
    output logic                  locked,
    output logic [WIDTH-1:0]      q
);

    arb_state_t       state_d,  state_q;
    logic [IDW-1:0]   ptr_d,    ptr_q;
    logic [IDW-1:0]   owner_d,  owner_q;
    logic [NREQ-1:0]  gnt_d,    gnt_q;
    logic [IDW-1:0]   gnt_id_d, gnt_id_q;

    rr_pick_t         pick;
    logic             grant_found;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] win_data;

    assign pick = rr_pick(MAX_NREQ'(req), MAX_IDW'(ptr_q), NREQ);

    // A locked owner that keeps both req and lock asserted keeps the register
    // and the pointer stays put. Any other case falls back to round-robin in
    // the same cycle; ptr already sits at owner+1, so a releasing owner gets
    // lowest priority.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_id_d    = gnt_id_q;
        grant_found = 1'b0;
        win         = '0;

        if (state_q == ARB_LOCKED && req[owner_q] && lock[owner_q]) begin
            grant_found = 1'b1;
            win         = owner_q;
        end else begin
            state_d = ARB_IDLE;
            if (pick.found) begin
                grant_found = 1'b1;
                win         = IDW'(pick.idx);
                ptr_d       = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                if (lock[win]) begin
                    state_d = ARB_LOCKED;
                    owner_d = win;
                end
            end
        end

        if (grant_found) begin
            gnt_id_d = win;
            gnt_d    = NREQ'(onehot(MAX_IDW'(win)));
        end else begin
            gnt_d    = '0;
        end
    end

    assign win_data = wdata[int'(win)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    dff_bank #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .en  (grant_found),
        .d   (win_data),
        .q   (q)
    );

    assign gnt     = gnt_q;
    assign gnt_vld = |gnt_q;
    assign gnt_id  = gnt_id_q;
    assign locked  = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for dff_write_arbiter (NREQ=4, WIDTH=8).
// Stimulus is applied on the falling edge; a reference model computes the
// expected registered outputs and queues them. A monitor pops one entry per
// rising edge and compares, and also tracks round-robin waiting times during
// the random phase.
// ----------------------------------------------------------------------------
module tb_dff_write_arbiter;

    localparam int         NREQ    = 4;
    localparam int         WIDTH   = 8;
    localparam int         IDW     = 2;
    localparam logic [7:0] RST_VAL = 8'h00;

    logic                  clk   = 1'b0;
    logic                  rst   = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ-1:0]       lock  = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic                  gnt_vld;
    logic [IDW-1:0]        gnt_id;
    logic                  locked;
    logic [WIDTH-1:0]      q;

    dff_write_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .locked  (locked),
        .q       (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [IDW-1:0]   gnt_id;
        logic [WIDTH-1:0] q;
        logic             locked;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    bit   mon_en     = 1'b0;
    bit   rand_phase = 1'b0;

    // Reference model state: pointer and owner as plain integers, -1 = no owner.
    int         m_ptr    = 0;
    int         m_owner  = -1;
    int         m_gnt_id = 0;
    logic [7:0] m_q      = RST_VAL;
    int         last_win = -1;

    // Drive one cycle of inputs, advance the model, and queue the outputs the
    // DUT must show after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq,
                                 input logic [NREQ-1:0] lk,
                                 input logic [NREQ*WIDTH-1:0] wd);
        exp_t e;
        int   win;
        @(negedge clk);
        rst   = r;
        req   = rq;
        lock  = lk;
        wdata = wd;
        win   = -1;
        if (!r) begin
            m_ptr    = 0;
            m_owner  = -1;
            m_gnt_id = 0;
            m_q      = RST_VAL;
        end else begin
            if (m_owner >= 0 && rq[m_owner] && lk[m_owner]) begin
                win = m_owner;
            end else begin
                m_owner = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (rq[j]) begin
                        win = j;
                        break;
                    end
                end
                if (win >= 0) begin
                    m_ptr = (win + 1) % NREQ;
                    if (lk[win]) m_owner = win;
                end
            end
            if (win >= 0) begin
                m_q      = wd[win*WIDTH +: WIDTH];
                m_gnt_id = win;
            end
        end
        e.gnt    = (win >= 0) ? NREQ'(1 << win) : '0;
        e.gnt_id = IDW'(m_gnt_id);
        e.q      = m_q;
        e.locked = (m_owner >= 0);
        last_win = win;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req_val);
        checks++;
        if (act !== req_val) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req_val, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge while enabled.
    initial begin : monitor
        exp_t            e;
        logic [NREQ-1:0] req_s;
        logic            rst_s;
        logic            lk_prev;
        logic [IDW-1:0]  id_prev;
        logic            arb;
        int              waits [NREQ];
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        forever begin
            @(posedge clk);
            if (mon_en) begin
                req_s   = req;
                rst_s   = rst;
                lk_prev = locked;
                id_prev = gnt_id;
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_empty: got no entry expected one at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("gnt",     32'(gnt),     32'(e.gnt));
                    checkOutput("gnt_id",  32'(gnt_id),  32'(e.gnt_id));
                    checkOutput("q",       32'(q),       32'(e.q));
                    checkOutput("locked",  32'(locked),  32'(e.locked));
                    checkOutput("gnt_vld", 32'(gnt_vld), 32'(|e.gnt));
                    checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
                end
                // Round-robin bound: a pending requester may see at most
                // NREQ-1 arbitration grants to others before its own grant.
                // Grants to a locked owner that keeps the lock are not counted.
                if (rand_phase) begin
                    if (!rst_s) begin
                        for (int i = 0; i < NREQ; i++) waits[i] = 0;
                    end else begin
                        arb = gnt_vld && !(lk_prev && locked && gnt_id == id_prev);
                        for (int i = 0; i < NREQ; i++) begin
                            if (gnt[i]) begin
                                checks++;
                                if (waits[i] > NREQ - 1) begin
                                    failures++;
                                    $display("[TB] FAIL starvation req%0d: got wait %0d expected at most %0d",
                                             i, waits[i], NREQ - 1);
                                end
                                waits[i] = 0;
                            end else if (req_s[i] && arb) begin
                                waits[i]++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [NREQ*WIDTH-1:0] wd_seq;
        logic [NREQ-1:0]       pend;
        logic [WIDTH-1:0]      data [NREQ];
        logic [NREQ-1:0]       rq;
        logic [NREQ-1:0]       lk;
        logic [NREQ*WIDTH-1:0] wd;
        logic                  r;

        wd_seq = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset with requests pending, then release
        applyStimulus(1'b0, 4'b1111, 4'b0000, wd_seq);
        applyStimulus(1'b0, 4'b1111, 4'b0000, wd_seq);
        applyStimulus(1'b1, 4'b1111, 4'b0000, wd_seq);

        // Full rotation with all requesters active
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b1111, 4'b0000, wd_seq);

        // Requester 2 locks while requester 0 waits, then releases
        applyStimulus(1'b1, 4'b0100, 4'b0100, wd_seq);
        applyStimulus(1'b1, 4'b0101, 4'b0100, wd_seq);
        applyStimulus(1'b1, 4'b0101, 4'b0100, wd_seq);
        applyStimulus(1'b1, 4'b0101, 4'b0000, wd_seq);

        // Load A5 then idle: q and gnt_id must hold
        applyStimulus(1'b1, 4'b0010, 4'b0000, {8'h00, 8'h00, 8'hA5, 8'h00});
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0000, 4'b0000, {8'h5A, 8'h5A, 8'h5A, 8'h5A});

        // Reset while locked on owner 1, then both 0 and 1 request
        applyStimulus(1'b1, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
        applyStimulus(1'b1, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h78, 8'h00});
        applyStimulus(1'b0, 4'b0010, 4'b0010, {8'h00, 8'h00, 8'h79, 8'h00});
        applyStimulus(1'b1, 4'b0011, 4'b0000, {8'h00, 8'h00, 8'h9C, 8'hC9});

        // Random traffic: requests held until granted, random lock hints,
        // occasional reset
        rand_phase = 1'b1;
        pend = '0;
        for (int i = 0; i < NREQ; i++) data[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_win == i) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    data[i] = WIDTH'($urandom);
                end
                lk[i] = ($urandom_range(0, 3) == 0);
            end
            rq = pend;
            wd = {data[3], data[2], data[1], data[0]};
            r  = ($urandom_range(0, 999) != 0);
            applyStimulus(r, rq, lk, wd);
        end

        @(negedge clk);
        mon_en = 1'b0;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
